turnike_arbiter: RTL and testbench

TURNIKE_ARBITER -- requirements
Module: turnike_arbiter

---
 rtl/turnike_arbiter.sv | 171 +++++++++++++++++
 tb/tb_turnike_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turnike_arbiter.sv
// Turnstile arbiter: debounced entry/exit buttons, round-robin grant, timed gate
// release, occupancy tracking and an RGB status lamp. Grant 1 cycle after pending.
module turnike_arbiter #(
  parameter int DEB_CYC   = 240_000,
  parameter int OPEN_CYC  = 120_000_000,
  parameter int LOCK_CYC  = 24_000_000,
  parameter int BLINK_CYC = 48_000_000,
  parameter int CAPACITY  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       pass,
  output logic       gate_in,
  output logic       gate_out,
  output logic [2:0] led,
  output logic [7:0] occupancy,
  output logic       full
);

  localparam int TMAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BLINK_CYC + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD  = TW'(LOCK_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_CYC / 2);
  localparam logic [7:0]    CAP      = 8'(CAPACITY);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, LOCK} state_t;

  // Index 0 = entry (btn1), index 1 = exit (btn2).
  logic [1:0]    s1_q, s2_q, deb_q, arm_q, press;
  logic [DW-1:0] dcnt_q [2];

  // Synchronizers reset to "pressed" so a button held through reset never arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '1;
      arm_q <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      s1_q <= {btn2, btn1};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] != deb_q[i]) begin
          if (dcnt_q[i] == DEB_LAST) begin
            deb_q[i]  <= s2_q[i];
            dcnt_q[i] <= '0;
          end else begin
            dcnt_q[i] <= dcnt_q[i] + DW'(1);
          end
        end else begin
          dcnt_q[i] <= '0;
        end
        if (s2_q[i]) arm_q[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++)
      press[i] = arm_q[i] & deb_q[i] & ~s2_q[i] & (dcnt_q[i] == DEB_LAST);
  end

  logic [BW-1:0] blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 blink_q <= '0;
    else if (blink_q == BLK_LAST) blink_q <= '0;
    else                        blink_q <= blink_q + BW'(1);
  end

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    pend_q;
  logic          rr_out_q, gin_q, gout_q, full_q;
  logic [2:0]    led_q;
  logic [7:0]    occ_q, occ_inc, occ_dec, occ_pass;
  logic          pick_out;

  always_comb begin
    pick_out = pend_q[1] & (~pend_q[0] | rr_out_q);
    occ_inc  = (occ_q >= CAP) ? CAP : occ_q + 8'd1;
    occ_dec  = (occ_q == 8'd0) ? 8'd0 : occ_q - 8'd1;
    occ_pass = (state_q == OPEN_IN) ? occ_inc : occ_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      pend_q   <= '0;
      rr_out_q <= 1'b1;
      gin_q    <= 1'b0;
      gout_q   <= 1'b0;
      led_q    <= 3'b111;
      occ_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      // A serve below overrides a same-cycle press: repeats while pending are dropped.
      pend_q <= pend_q | press;

      case (state_q)
        IDLE:              led_q <= (blink_q < BLK_HALF) ? 3'b101 : 3'b111;
        OPEN_IN, OPEN_OUT: led_q <= 3'b011;
        default:           led_q <= 3'b110;
      endcase

      case (state_q)
        IDLE: begin
          if (pick_out) begin
            pend_q[1] <= 1'b0;
            rr_out_q  <= 1'b0;
            if (occ_q == 8'd0) begin
              state_q <= LOCK;
              timer_q <= LOCK_LD;
            end else begin
              state_q <= OPEN_OUT;
              gout_q  <= 1'b1;
              timer_q <= OPEN_LD;
            end
          end else if (pend_q[0]) begin
            pend_q[0] <= 1'b0;
            rr_out_q  <= 1'b1;
            if (full_q) begin
              state_q <= LOCK;
              timer_q <= LOCK_LD;
            end else begin
              state_q <= OPEN_IN;
              gin_q   <= 1'b1;
              timer_q <= OPEN_LD;
            end
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (pass || timer_q == '0) begin
            state_q <= LOCK;
            timer_q <= LOCK_LD;
            gin_q   <= 1'b0;
            gout_q  <= 1'b0;
            if (pass) begin
              occ_q  <= occ_pass;
              full_q <= (occ_pass == CAP);
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        LOCK: begin
          if (timer_q == '0) state_q <= IDLE;
          else               timer_q <= timer_q - TW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gate_in   = gin_q;
  assign gate_out  = gout_q;
  assign led       = led_q;
  assign occupancy = occ_q;
  assign full      = full_q;

endmodule

// File: tb/tb_turnike_arbiter.sv
// Bench for turnike_arbiter with short timing parameters; grant/refusal events
// are matched against an expected-event queue filled as stimulus is driven.
module tb_turnike_arbiter;

  localparam int EV_IN   = 0;
  localparam int EV_OUT  = 1;
  localparam int EV_REF  = 2;
  localparam int EV_NONE = 3;

  typedef struct {
    int kind;
    int occ;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, btn1, btn2, pass;
  logic       gate_in, gate_out, full;
  logic [2:0] led;
  logic [7:0] occupancy;

  int   n_chk = 0;
  int   n_err = 0;
  int   mocc  = 0;
  exp_t sb[$];

  turnike_arbiter #(
    .DEB_CYC(4), .OPEN_CYC(20), .LOCK_CYC(8), .BLINK_CYC(16), .CAPACITY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn1(btn1), .btn2(btn2), .pass(pass),
    .gate_in(gate_in), .gate_out(gate_out), .led(led),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int occ);
    exp_t e;
    e.kind = kind;
    e.occ  = occ;
    sb.push_back(e);
  endtask

  task automatic wait_gate(input bit dir, input string tag);
    int n = 0;
    while (((dir ? gate_out : gate_in) == 1'b0) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, int'(dir ? gate_out : gate_in), 1);
  endtask

  task automatic wait_led(input logic [2:0] v, input string tag);
    int n = 0;
    while (led != v && n < 40) begin
      tick();
      n++;
    end
    chk(tag, int'(led), int'(v));
  endtask

  task automatic do_pass();
    pass = 1'b1;
    tick();
    pass = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (12) tick();
  endtask

  // Event monitor: gate rising edges and idle->red lamp changes (refusals).
  initial begin
    logic       gin_p = 1'b0, gout_p = 1'b0;
    logic [2:0] led_p = 3'b111;
    int         ev;
    exp_t       e;
    forever begin
      @(negedge clk);
      chk("gates_excl", int'(gate_in & gate_out), 0);
      ev = -1;
      if (gate_in && !gin_p)        ev = EV_IN;
      else if (gate_out && !gout_p) ev = EV_OUT;
      else if (led == 3'b110 && (led_p == 3'b101 || led_p == 3'b111)) ev = EV_REF;
      if (ev >= 0) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_kind", ev, e.kind);
          chk("sb_occ", int'(occupancy), e.occ);
        end else begin
          chk("sb_unexpected", ev, EV_NONE);
        end
      end
      gin_p  = gate_in;
      gout_p = gate_out;
      led_p  = led;
    end
  end

  initial begin
    rst_n = 1'b0; btn1 = 1'b1; btn2 = 1'b1; pass = 1'b0;
    repeat (3) tick();
    chk("rst_gate_in", int'(gate_in), 0);
    chk("rst_gate_out", int'(gate_out), 0);
    chk("rst_led", int'(led), 7);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_full", int'(full), 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Entry with pass, lamp and lock duration.
    push(EV_IN, mocc);
    btn1 = 1'b0;
    wait_gate(1'b0, "s1_gate");
    btn1 = 1'b1;
    tick();
    chk("s1_led_green", int'(led), 3);
    repeat (3) tick();
    do_pass(); mocc = 1;
    chk("s1_gate_drop", int'(gate_in), 0);
    chk("s1_occ", int'(occupancy), 1);
    chk("s1_full", int'(full), 0);
    tick();
    chk("s1_led_red_first", int'(led), 6);
    repeat (7) tick();
    chk("s1_led_red_last", int'(led), 6);
    tick();
    chk("s1_led_left_red", int'(led == 3'b110), 0);

    // Simultaneous presses: exit first, entry after its lock.
    push(EV_OUT, 1);
    push(EV_IN, 0);
    btn1 = 1'b0; btn2 = 1'b0;
    wait_gate(1'b1, "s2_out");
    chk("s2_no_in", int'(gate_in), 0);
    repeat (2) tick();
    do_pass(); mocc = 0;
    chk("s2_occ_dec", int'(occupancy), 0);
    btn1 = 1'b1; btn2 = 1'b1;
    wait_gate(1'b0, "s2_in");
    chk("s2_no_out", int'(gate_out), 0);
    repeat (2) tick();
    do_pass(); mocc = 1;
    chk("s2_occ_inc", int'(occupancy), 1);
    wait_idle();

    // Timeout without pass, and pass ignored during lock.
    push(EV_IN, mocc);
    btn1 = 1'b0;
    wait_gate(1'b0, "s3_gate");
    btn1 = 1'b1;
    repeat (19) tick();
    chk("s3_gate_hold", int'(gate_in), 1);
    tick();
    chk("s3_gate_timeout", int'(gate_in), 0);
    chk("s3_occ_same", int'(occupancy), 1);
    do_pass();
    chk("s3_pass_ignored", int'(occupancy), 1);
    chk("s3_led_red", int'(led), 6);
    wait_idle();

    // Fill to capacity, refuse entry, empty out, refuse exit.
    push(EV_IN, mocc);
    btn1 = 1'b0;
    wait_gate(1'b0, "s4_fill");
    btn1 = 1'b1;
    repeat (2) tick();
    do_pass(); mocc = 2;
    chk("s4_occ_full", int'(occupancy), 2);
    chk("s4_full", int'(full), 1);
    wait_idle();
    push(EV_REF, mocc);
    btn1 = 1'b0;
    wait_led(3'b110, "s4_refuse_in");
    btn1 = 1'b1;
    chk("s4_refuse_no_gate", int'(gate_in), 0);
    chk("s4_refuse_occ", int'(occupancy), 2);
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      push(EV_OUT, mocc);
      btn2 = 1'b0;
      wait_gate(1'b1, "s4_exit");
      btn2 = 1'b1;
      repeat (2) tick();
      do_pass(); mocc--;
      chk("s4_exit_occ", int'(occupancy), mocc);
      chk("s4_exit_full", int'(full), 0);
      wait_idle();
    end
    push(EV_REF, mocc);
    btn2 = 1'b0;
    wait_led(3'b110, "s4_refuse_out");
    btn2 = 1'b1;
    chk("s4_refuse_no_out", int'(gate_out), 0);
    chk("s4_empty_occ", int'(occupancy), 0);
    wait_idle();

    // Last served was the refused exit, so entry now wins a tie.
    push(EV_IN, 0);
    push(EV_OUT, 1);
    btn1 = 1'b0; btn2 = 1'b0;
    wait_gate(1'b0, "rr_in_first");
    chk("rr_no_out", int'(gate_out), 0);
    repeat (2) tick();
    do_pass(); mocc = 1;
    btn1 = 1'b1; btn2 = 1'b1;
    wait_gate(1'b1, "rr_out_second");
    repeat (2) tick();
    do_pass(); mocc = 0;
    chk("rr_occ", int'(occupancy), 0);
    wait_idle();

    // Short glitch must not produce a request.
    btn1 = 1'b0;
    repeat (3) tick();
    btn1 = 1'b1;
    repeat (30) tick();
    chk("glitch_no_gate", int'(gate_in), 0);

    // Reset mid-open while the button stays held, then blink pattern.
    push(EV_IN, mocc);
    btn1 = 1'b0;
    wait_gate(1'b0, "s6_gate");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("s6_rst_gate", int'(gate_in), 0);
    chk("s6_rst_led", int'(led), 7);
    chk("s6_rst_occ", int'(occupancy), 0);
    repeat (2) tick();
    rst_n = 1'b1; mocc = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("blink", int'(led), (((k - 1) % 16) < 8) ? 5 : 7);
    end
    chk("held_no_gate", int'(gate_in), 0);
    btn1 = 1'b1;
    repeat (10) tick();
    push(EV_IN, mocc);
    btn1 = 1'b0;
    wait_gate(1'b0, "s6_repress");
    btn1 = 1'b1;
    repeat (2) tick();
    do_pass(); mocc = 1;
    chk("s6_occ", int'(occupancy), 1);
    wait_idle();

    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
